jtframe_i2s_tx: RTL

Parametrised I2S / left-justified serial audio transmitter for JTFRAME targets that drive an external DAC, such as Poseidon-class boards.
- Generates BCLK, LRCK and SDATA from the system clock, so no board-specific 50 MHz audio clock is needed.
- Accepts the frame's stereo sound bus and sample strobe.
- Handles input width and signedness and slot width, with a mute control.
- Issues one-cycle frame pulses so the game side can pace samples.

---
 rtl/jtframe_i2s_tx.sv | 107 ++++++++++
 1 files changed

// File: rtl/jtframe_i2s_tx.sv
// I2S / left-justified stereo transmitter clocked from clk; BCLK is derived by an
// integer divider and each frame is latched from the sample holding registers.
module jtframe_i2s_tx #(
   parameter int CLKDIV     = 8,
   parameter int SNDW       = 16,
   parameter int SLOTW      = 32,
   parameter int SIGNED_SND = 1,
   parameter int FORMAT     = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [SNDW-1:0] snd_left,
   input  logic [SNDW-1:0] snd_right,
   input  logic            sample,
   input  logic            mute,
   output logic            bclk,
   output logic            lrck,
   output logic            sdata,
   output logic            frame
);
   // I2S needs one extra bit to carry the previous frame's right LSB into bitcnt 0.
   localparam int         SHW      = 2*SLOTW + ((FORMAT == 0) ? 1 : 0);
   localparam logic [7:0] CNT_LAST = 8'(CLKDIV-1);
   localparam logic [6:0] BIT_LAST = 7'(2*SLOTW-1);
   localparam logic [6:0] BIT_R    = 7'(SLOTW);

   logic [7:0]       cnt;
   logic [6:0]       bitcnt;
   logic [6:0]       bitcnt_nx;
   logic [SNDW-1:0]  hold_l;
   logic [SNDW-1:0]  hold_r;
   logic [SHW-1:0]   shifter;
   logic [SHW-1:0]   load_val;
   logic [SLOTW-1:0] slot_l;
   logic [SLOTW-1:0] slot_r;
   logic             tick;
   logic             fall;
   logic             wrap;

   // Sign-aligned placement: the converted sample occupies the slot MSBs.
   function automatic logic [SLOTW-1:0] to_slot(input logic [SNDW-1:0] s);
      logic [SNDW-1:0] c;
      c = s;
      if (SIGNED_SND == 0) c[SNDW-1] = ~s[SNDW-1];
      return {c, {(SLOTW-SNDW){1'b0}}};
   endfunction

   assign tick      = (cnt == CNT_LAST);
   assign fall      = tick & bclk;
   assign wrap      = (bitcnt == BIT_LAST);
   assign bitcnt_nx = wrap ? 7'd0 : bitcnt + 7'd1;
   assign slot_l    = mute ? '0 : to_slot(hold_l);
   assign slot_r    = mute ? '0 : to_slot(hold_r);
   assign sdata     = shifter[SHW-1];

   generate
      if (FORMAT == 0) begin : g_i2s
         assign load_val = {shifter[SHW-2], slot_l, slot_r};
      end else begin : g_lj
         assign load_val = {slot_l, slot_r};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= 8'd0;
         bclk <= 1'b0;
      end else if (tick) begin
         cnt  <= 8'd0;
         bclk <= ~bclk;
      end else begin
         cnt  <= cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_l <= '0;
         hold_r <= '0;
      end else if (sample) begin
         hold_l <= snd_left;
         hold_r <= snd_right;
      end
   end

   // Everything the DAC sees changes on the BCLK falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bitcnt  <= BIT_LAST;
         lrck    <= 1'b0;
         frame   <= 1'b0;
         shifter <= '0;
      end else begin
         frame <= 1'b0;
         if (fall) begin
            bitcnt <= bitcnt_nx;
            lrck   <= (bitcnt_nx >= BIT_R);
            if (wrap) begin
               shifter <= load_val;
               frame   <= 1'b1;
            end else begin
               shifter <= {shifter[SHW-2:0], 1'b0};
            end
         end
      end
   end
endmodule
